bayer_stream_gen: RTL

BAYER_STREAM_GEN -- requirements
Module: bayer_stream_gen

---
 rtl/bayer_stream_gen.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/bayer_stream_gen.sv
// Raster test-pattern source that emits Bayer-mosaic pixels with line/frame blanking.
// Four patterns are selectable per frame: ramp, colour bars, checker and a 12-bit PRBS.
module bayer_stream_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 32,
  parameter int V_ACTIVE = 960,
  parameter int V_BLANK  = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iSTOP,
  input  logic [1:0]  iMODE,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic        oFVAL,
  output logic [15:0] oFRAME_CNT,
  output logic        oBUSY
);

  localparam int LINE_LEN  = H_ACTIVE + H_BLANK;
  localparam int VB_CYCLES = V_BLANK * LINE_LEN;
  localparam int CNT_MAX   = (VB_CYCLES > H_BLANK) ? VB_CYCLES : H_BLANK;
  localparam int CNT_W     = $clog2(CNT_MAX + 2);

  localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [CNT_W-1:0] VB_LAST   = CNT_W'((VB_CYCLES > 0) ? VB_CYCLES - 1 : 0);
  localparam logic [10:0]      X_LAST    = 11'(H_ACTIVE - 1);
  localparam logic [10:0]      Y_LAST    = 11'(V_ACTIVE - 1);
  localparam logic [11:0]      LFSR_SEED = 12'hACE;
  localparam bit               HAS_HB    = (H_BLANK > 0);
  localparam bit               HAS_VB    = (V_BLANK > 0);

  typedef enum logic [1:0] {IDLE, LINE, HBLANK, VBLANK} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [10:0]      x_q, x_d, y_q, y_d;
  logic [11:0]      data_q, data_d, lfsr_q, lfsr_d, pix_lfsr;
  logic [15:0]      fcnt_q, fcnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             dval_q, dval_d, stop_q, stop_d, run_q, run_d;
  logic             line_end, last_line, eol, frame_done, stop_now, new_frame;

  // Taps 12,11,10,4 (1-based) feed bit 0; the register shifts towards the MSB.
  function automatic logic [11:0] lfsr_step(input logic [11:0] s);
    return {s[10:0], s[11] ^ s[10] ^ s[9] ^ s[3]};
  endfunction

  function automatic logic [11:0] pattern(input logic [1:0] m, input logic [10:0] x,
                                          input logic [10:0] y, input logic [11:0] prbs);
    logic [2:0] bar;
    logic       on;
    bar = x[10:8];
    on  = 1'b0;
    pattern = 12'h000;
    unique case (m)
      2'd0: pattern = {1'b0, x} + {1'b0, y};
      2'd1: begin
        unique case ({y[0], x[0]})
          2'b01:   on = bar[0];
          2'b10:   on = bar[2];
          default: on = bar[1];
        endcase
        pattern = {12{on}};
      end
      2'd2: pattern = {12{x[3] ^ y[3]}};
      default: pattern = prbs;
    endcase
  endfunction

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    stop_d    = stop_q;
    mode_d    = mode_q;
    lfsr_d    = lfsr_q;
    fcnt_d    = fcnt_q;
    dval_d    = 1'b0;
    data_d    = 12'h000;
    pix_lfsr  = lfsr_q;
    new_frame = 1'b0;

    line_end   = (x_q == X_LAST);
    last_line  = (y_q == Y_LAST);
    stop_now   = stop_q | iSTOP;
    // End of a full line period: after the blank, or right at the last pixel when there is no blank.
    eol        = ((state_q == LINE) && line_end && !HAS_HB) ||
                 ((state_q == HBLANK) && (cnt_q == HB_LAST));
    frame_done = ((state_q == VBLANK) && (cnt_q == VB_LAST)) ||
                 (!HAS_VB && eol && last_line);

    unique case (state_q)
      IDLE: if (iSTART) begin
        new_frame = 1'b1;
        stop_d    = iSTOP;
      end
      LINE: begin
        stop_d = stop_now;
        if (!line_end) begin
          x_d    = x_q + 11'd1;
          dval_d = 1'b1;
        end else if (HAS_HB) begin
          state_d = HBLANK;
          cnt_d   = '0;
        end
      end
      HBLANK, VBLANK: begin
        stop_d = stop_now;
        cnt_d  = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (eol) begin
      if (!last_line) begin
        state_d = LINE;
        x_d     = '0;
        y_d     = y_q + 11'd1;
        dval_d  = 1'b1;
      end else if (HAS_VB) begin
        state_d = VBLANK;
        cnt_d   = '0;
      end
    end

    if (frame_done) begin
      fcnt_d = fcnt_q + 16'd1;
      if (stop_now) begin
        state_d = IDLE;
        stop_d  = 1'b0;
      end else begin
        new_frame = 1'b1;
      end
    end

    if (new_frame) begin
      state_d  = LINE;
      x_d      = '0;
      y_d      = '0;
      dval_d   = 1'b1;
      mode_d   = iMODE;
      pix_lfsr = LFSR_SEED;
    end

    // lfsr_q always holds the value for the next emitted pixel.
    if (dval_d) begin
      data_d = pattern(mode_d, x_d, y_d, pix_lfsr);
      lfsr_d = lfsr_step(pix_lfsr);
    end

    run_d = (state_d != IDLE);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      fcnt_q  <= '0;
      mode_q  <= '0;
      dval_q  <= 1'b0;
      stop_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      lfsr_q  <= lfsr_d;
      fcnt_q  <= fcnt_d;
      mode_q  <= mode_d;
      dval_q  <= dval_d;
      stop_q  <= stop_d;
      run_q   <= run_d;
    end
  end

  assign oX_Cont    = x_q;
  assign oY_Cont    = y_q;
  assign oDATA      = data_q;
  assign oDVAL      = dval_q;
  assign oFVAL      = run_q;
  assign oBUSY      = run_q;
  assign oFRAME_CNT = fcnt_q;

endmodule
